// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default memory word-address and data widths
//   grant_e                 : which requester owns the memory port this cycle
//   slot_state_e            : occupancy of a one-entry response slot
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_LS
  } grant_e;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

endpackage

// File: rtl/mem_port_rsp_slot.sv
// One-entry registered response slot with valid/ready back-pressure.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_data this edge (slot must be free)
//   load_data   : response word to capture
//   rsp_ready   : consumer takes the held response
//   rsp_valid   : a response is held
//   rsp_data    : held response word
//   free        : slot can accept a load this cycle (empty, or draining now)
module mem_port_rsp_slot
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              free
);

  slot_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready && !load) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else if (load) begin
      rsp_data <= load_data;
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign free      = (state_q == SLOT_EMPTY) || rsp_ready;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported instruction/data memory between instruction
// fetch (IF) and the load/store unit (LS). At most one access is granted per
// cycle; LS has priority unless IF has been denied STARVE_MAX consecutive
// eligible cycles. Each result returns one cycle later through a registered,
// back-pressurable response slot per requester.
// Optional build macro: MEM_PORT_ARBITER_STATS_EN adds 32-bit wrapping
// counters stat_if_grants, stat_ls_grants and stat_if_stall.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   if_req_valid/if_req_ready/if_addr  : IF read request
//   if_rsp_valid/if_rsp_ready/if_rsp_data : IF response
//   ls_req_valid/ls_req_ready/ls_we/ls_addr/ls_wdata : LS request
//   ls_rsp_valid/ls_rsp_ready/ls_rsp_data : LS response (0 data for write ack)
//   mem_wen/mem_ren/mem_waddr/mem_raddr/mem_wdata : memory drive
//   mem_rdata                          : combinational read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  input  logic              ls_rsp_ready,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_ls_grants,
  output logic [31:0]       stat_if_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  grant_e           grant;
  logic             if_free, ls_free;
  logic             if_elig, ls_elig;
  logic [DATA_W-1:0] ls_load_data;

  assign if_elig = if_req_valid && if_free;
  assign ls_elig = ls_req_valid && ls_free;

  // Grant is forced to none while reset is held so no memory write can be
  // committed by an edge that occurs during reset.
  always_comb begin
    grant = GNT_NONE;
    if (!rst_n) begin
      grant = GNT_NONE;
    end else if (if_elig && ls_elig) begin
      grant = (starve_cnt == CNT_MAX) ? GNT_IF : GNT_LS;
    end else if (if_elig) begin
      grant = GNT_IF;
    end else if (ls_elig) begin
      grant = GNT_LS;
    end
  end

  assign if_req_ready = (grant == GNT_IF);
  assign ls_req_ready = (grant == GNT_LS);

  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_waddr = '0;
    mem_raddr = '0;
    mem_wdata = '0;
    case (grant)
      GNT_IF: begin
        mem_ren   = 1'b1;
        mem_raddr = if_addr;
      end
      GNT_LS: begin
        if (ls_we) begin
          mem_wen   = 1'b1;
          mem_waddr = ls_addr;
          mem_wdata = ls_wdata;
        end else begin
          mem_ren   = 1'b1;
          mem_raddr = ls_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_req_ready) begin
      starve_cnt <= '0;
    end else if (if_elig && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign ls_load_data = ls_we ? '0 : mem_rdata;

  mem_port_rsp_slot #(.DATA_W(DATA_W)) u_if_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (if_req_ready),
    .load_data (mem_rdata),
    .rsp_ready (if_rsp_ready),
    .rsp_valid (if_rsp_valid),
    .rsp_data  (if_rsp_data),
    .free      (if_free)
  );

  mem_port_rsp_slot #(.DATA_W(DATA_W)) u_ls_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ls_req_ready),
    .load_data (ls_load_data),
    .rsp_ready (ls_rsp_ready),
    .rsp_valid (ls_rsp_valid),
    .rsp_data  (ls_rsp_data),
    .free      (ls_free)
  );

`ifdef MEM_PORT_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_grants <= '0;
      stat_ls_grants <= '0;
      stat_if_stall  <= '0;
    end else begin
      if (if_req_valid && if_req_ready)  stat_if_grants <= stat_if_grants + 32'd1;
      if (ls_req_valid && ls_req_ready)  stat_ls_grants <= stat_ls_grants + 32'd1;
      if (if_req_valid && !if_req_ready) stat_if_stall  <= stat_if_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [15:0] if_addr = '0;
  logic        if_rsp_valid, if_rsp_ready = 1'b0;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid = 1'b0, ls_req_ready;
  logic        ls_we = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_rsp_valid, ls_rsp_ready = 1'b0;
  logic [31:0] ls_rsp_data;
  logic        mem_wen, mem_ren;
  logic [15:0] mem_waddr, mem_raddr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] stat_if_grants, stat_ls_grants, stat_if_stall;
`endif

  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [0:63];
  assign mem_rdata = mem[mem_raddr];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_data(ls_rsp_data),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARBITER_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_ls_grants(stat_ls_grants),
    .stat_if_stall(stat_if_stall)
`endif
  );

  typedef struct {
    logic        ifv; logic [15:0] ifa; logic ifr;
    logic        lsv; logic lwe; logic [15:0] lsa; logic [31:0] lwd; logic lsr;
    logic        e_ifrdy, e_lsrdy, e_ren; logic [15:0] e_raddr;
    logic        e_wen; logic [15:0] e_waddr; logic [31:0] e_wdata;
    logic        e_ifv; logic [31:0] e_ifd; logic e_lsv; logic [31:0] e_lsd;
  } vec_t;

  function automatic vec_t mk(
    input logic ifv, input logic [15:0] ifa, input logic ifr,
    input logic lsv, input logic lwe, input logic [15:0] lsa, input logic [31:0] lwd,
    input logic lsr,
    input logic e_ifrdy, input logic e_lsrdy, input logic e_ren, input logic [15:0] e_raddr,
    input logic e_wen, input logic [15:0] e_waddr, input logic [31:0] e_wdata,
    input logic e_ifv, input logic [31:0] e_ifd, input logic e_lsv, input logic [31:0] e_lsd);
    vec_t v;
    v.ifv = ifv; v.ifa = ifa; v.ifr = ifr;
    v.lsv = lsv; v.lwe = lwe; v.lsa = lsa; v.lwd = lwd; v.lsr = lsr;
    v.e_ifrdy = e_ifrdy; v.e_lsrdy = e_lsrdy; v.e_ren = e_ren; v.e_raddr = e_raddr;
    v.e_wen = e_wen; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_ifv = e_ifv; v.e_ifd = e_ifd; v.e_lsv = e_lsv; v.e_lsd = e_lsd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ifv, input logic [15:0] ifa, input logic ifr,
                       input logic lsv, input logic lwe, input logic [15:0] lsa,
                       input logic [31:0] lwd, input logic lsr);
    if_req_valid = ifv; if_addr = ifa; if_rsp_ready = ifr;
    ls_req_valid = lsv; ls_we = lwe; ls_addr = lsa; ls_wdata = lwd; ls_rsp_ready = lsr;
  endtask

  // Advance one edge, committing any write the DUT presented to the memory.
  task automatic clock_edge();
    logic w; logic [15:0] a; logic [31:0] d;
    w = mem_wen; a = mem_waddr; d = mem_wdata;
    @(posedge clk);
    if (w) mem[a] <= d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_if_rsp_valid", 32'(if_rsp_valid), 0);
    check("rst_ls_rsp_valid", 32'(ls_rsp_valid), 0);
    check("rst_if_rsp_data", if_rsp_data, 0);
    check("rst_ls_rsp_data", ls_rsp_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [10];

  // Reference model state for the random phase
  bit          m_if_full, m_ls_full;
  logic [31:0] m_if_data, m_ls_data;
  int          m_wait;
  int          m_if_g, m_ls_g, m_if_stall;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i) * 32'h9E3779B1;
    mem[4] = 32'hDEADBEEF;

    tbl[0] = mk(1, 16'h4, 1,  0, 0, 0, 0, 1,  1, 0, 1, 16'h4, 0, 0, 0,  1, 32'hDEADBEEF, 0, 0);
    tbl[1] = mk(0, 0, 1,      0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0);
    tbl[2] = mk(0, 0, 1,      1, 1, 16'h10, 32'h12345678, 1,
                0, 1, 0, 0, 1, 16'h10, 32'h12345678,                    0, 0, 1, 0);
    tbl[3] = mk(0, 0, 1,      1, 0, 16'h10, 0, 1,
                0, 1, 1, 16'h10, 0, 0, 0,                               0, 0, 1, 32'h12345678);
    tbl[4] = mk(0, 0, 1,      0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0);
    tbl[5] = mk(0, 0, 1,      1, 0, 16'h10, 0, 0,
                0, 1, 1, 16'h10, 0, 0, 0,                               0, 0, 1, 32'h12345678);
    tbl[6] = mk(1, 16'h4, 1,  1, 0, 16'h4, 0, 0,
                1, 0, 1, 16'h4, 0, 0, 0,                1, 32'hDEADBEEF, 1, 32'h12345678);
    tbl[7] = tbl[6];
    tbl[8] = mk(1, 16'h4, 1,  1, 0, 16'h4, 0, 1,
                0, 1, 1, 16'h4, 0, 0, 0,                                0, 0, 1, 32'hDEADBEEF);
    tbl[9] = mk(1, 16'h4, 1,  0, 0, 0, 0, 1,
                1, 0, 1, 16'h4, 0, 0, 0,                1, 32'hDEADBEEF, 0, 0);

    do_reset();

    // Directed table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].ifv, tbl[i].ifa, tbl[i].ifr, tbl[i].lsv, tbl[i].lwe,
            tbl[i].lsa, tbl[i].lwd, tbl[i].lsr);
      #1;
      check($sformatf("tbl%0d_if_req_ready", i), 32'(if_req_ready), 32'(tbl[i].e_ifrdy));
      check($sformatf("tbl%0d_ls_req_ready", i), 32'(ls_req_ready), 32'(tbl[i].e_lsrdy));
      check($sformatf("tbl%0d_mem_ren", i), 32'(mem_ren), 32'(tbl[i].e_ren));
      check($sformatf("tbl%0d_mem_raddr", i), 32'(mem_raddr), 32'(tbl[i].e_raddr));
      check($sformatf("tbl%0d_mem_wen", i), 32'(mem_wen), 32'(tbl[i].e_wen));
      check($sformatf("tbl%0d_mem_waddr", i), 32'(mem_waddr), 32'(tbl[i].e_waddr));
      check($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      clock_edge();
      check($sformatf("tbl%0d_if_rsp_valid", i), 32'(if_rsp_valid), 32'(tbl[i].e_ifv));
      check($sformatf("tbl%0d_ls_rsp_valid", i), 32'(ls_rsp_valid), 32'(tbl[i].e_lsv));
      if (tbl[i].e_ifv) check($sformatf("tbl%0d_if_rsp_data", i), if_rsp_data, tbl[i].e_ifd);
      if (tbl[i].e_lsv) check($sformatf("tbl%0d_ls_rsp_data", i), ls_rsp_data, tbl[i].e_lsd);
      n_vec++;
    end

    // Starvation pattern: both continuously eligible -> LS x4, IF x1, repeating
    do_reset();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      drive(1, 16'h4, 1, 1, 0, 16'h10, 0, 1);
      #1;
      check($sformatf("starve%0d_if_req_ready", k), 32'(if_req_ready), 32'((k % 5) == 4));
      check($sformatf("starve%0d_ls_req_ready", k), 32'(ls_req_ready), 32'((k % 5) != 4));
      clock_edge();
      n_vec++;
    end

    // Asynchronous reset with both slots full
    do_reset();
    @(negedge clk);
    drive(1, 16'h4, 0, 1, 0, 16'h10, 0, 0);
    clock_edge();
    @(negedge clk);
    clock_edge();
    check("full_if_rsp_valid", 32'(if_rsp_valid), 1);
    check("full_ls_rsp_valid", 32'(ls_rsp_valid), 1);
    #1;
    rst_n = 1'b0;
    drive(1, 16'h4, 0, 1, 1, 16'h20, 32'hCAFEF00D, 0);
    #1;
    check("arst_if_rsp_valid", 32'(if_rsp_valid), 0);
    check("arst_ls_rsp_valid", 32'(ls_rsp_valid), 0);
    check("arst_if_rsp_data", if_rsp_data, 0);
    check("arst_mem_wen", 32'(mem_wen), 0);
    check("arst_ls_req_ready", 32'(ls_req_ready), 0);
    clock_edge();
    check("arst_no_write", mem[16'h20], 32'h20 * 32'h9E3779B1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 16'h4, 1, 1, 0, 16'h10, 0, 1);
    #1;
    check("post_rst_ls_req_ready", 32'(ls_req_ready), 1);
    check("post_rst_if_req_ready", 32'(if_req_ready), 0);
    clock_edge();
    check("post_rst_ls_rsp_data", ls_rsp_data, 32'h12345678);
    n_vec++;

`ifdef MEM_PORT_ARBITER_STATS_EN
    // 10 IF grants with 3 stall cycles in between
    do_reset();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      drive(1, 16'(k), (k >= 4) ? 1'b1 : 1'b0, 0, 0, 0, 0, 1);
      clock_edge();
    end
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0, 0, 1);
    clock_edge();
    check("stat_if_grants_10", stat_if_grants, 10);
    check("stat_if_stall_3", stat_if_stall, 3);
    check("stat_ls_grants_0", stat_ls_grants, 0);
`endif

    // Randomized phase against the reference model
    do_reset();
    for (int a = 0; a < 64; a++) ref_mem[a] = mem[a];
    m_if_full = 0; m_ls_full = 0; m_if_data = '0; m_ls_data = '0; m_wait = 0;
    m_if_g = 0; m_ls_g = 0; m_if_stall = 0;
    begin
      bit          if_pend, ls_pend, r_we;
      logic [15:0] r_ifa, r_lsa;
      logic [31:0] r_wd;
      bit          if_ok, ls_ok, g_if, g_ls, got_if, got_ls;
      if_pend = 0; ls_pend = 0; r_we = 0; r_ifa = 0; r_lsa = 0; r_wd = 0;
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        if (!if_pend) begin
          if_pend = ($urandom % 4) != 0;
          r_ifa = 16'($urandom % 64);
        end
        if (!ls_pend) begin
          ls_pend = ($urandom % 3) != 0;
          r_we = 1'($urandom % 2);
          r_lsa = 16'($urandom % 64);
          r_wd = $urandom;
        end
        drive(if_pend, r_ifa, ($urandom % 3) != 0, ls_pend, r_we, r_lsa, r_wd,
              ($urandom % 3) != 0);
        #1;
        if_ok = if_req_valid && (!m_if_full || if_rsp_ready);
        ls_ok = ls_req_valid && (!m_ls_full || ls_rsp_ready);
        if (if_ok && ls_ok) begin
          g_if = (m_wait >= SMAX);
          g_ls = !g_if;
        end else begin
          g_if = if_ok;
          g_ls = ls_ok;
        end
        check("rnd_if_req_ready", 32'(if_req_ready), 32'(g_if));
        check("rnd_ls_req_ready", 32'(ls_req_ready), 32'(g_ls));
        check("rnd_mem_ren", 32'(mem_ren), 32'(g_if || (g_ls && !ls_we)));
        check("rnd_mem_raddr", 32'(mem_raddr),
              g_if ? 32'(if_addr) : ((g_ls && !ls_we) ? 32'(ls_addr) : 0));
        check("rnd_mem_wen", 32'(mem_wen), 32'(g_ls && ls_we));
        check("rnd_mem_waddr", 32'(mem_waddr), (g_ls && ls_we) ? 32'(ls_addr) : 0);
        check("rnd_mem_wdata", mem_wdata, (g_ls && ls_we) ? ls_wdata : 0);
        got_if = if_req_ready;
        got_ls = ls_req_ready;
        if (g_if) m_if_g++;
        if (g_ls) m_ls_g++;
        if (if_req_valid && !g_if) m_if_stall++;
        clock_edge();
        if (g_if) begin
          m_if_full = 1; m_if_data = ref_mem[if_addr[5:0]];
        end else if (if_rsp_ready) begin
          m_if_full = 0;
        end
        if (g_ls) begin
          m_ls_full = 1;
          m_ls_data = ls_we ? 32'h0 : ref_mem[ls_addr[5:0]];
          if (ls_we) ref_mem[ls_addr[5:0]] = ls_wdata;
        end else if (ls_rsp_ready) begin
          m_ls_full = 0;
        end
        if (g_if) m_wait = 0;
        else if (if_ok && m_wait < SMAX) m_wait++;
        check("rnd_if_rsp_valid", 32'(if_rsp_valid), 32'(m_if_full));
        check("rnd_ls_rsp_valid", 32'(ls_rsp_valid), 32'(m_ls_full));
        if (m_if_full) check("rnd_if_rsp_data", if_rsp_data, m_if_data);
        if (m_ls_full) check("rnd_ls_rsp_data", ls_rsp_data, m_ls_data);
        if (got_if) if_pend = 0;
        if (got_ls) ls_pend = 0;
        n_vec++;
      end
    end
`ifdef MEM_PORT_ARBITER_STATS_EN
    check("rnd_stat_if_grants", stat_if_grants, 32'(m_if_g));
    check("rnd_stat_ls_grants", stat_ls_grants, 32'(m_ls_g));
    check("rnd_stat_if_stall", stat_if_stall, 32'(m_if_stall));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported combined instruction/data memory (16-bit word address, 32-bit data, synchronous write, combinational read) between two requesters: instruction fetch (IF) and load/store unit (LS).
- Grants at most one access per cycle.
- Drives the memory's wen/ren/waddr/raddr/wdata.
- Returns each result through a registered, back-pressurable response slot per requester.
- Sits between the core pipeline and the memory block.

Parameters:
ADDR_W, 16, memory word-address width
DATA_W, 32, memory data width
STARVE_MAX, 4, consecutive denied IF cycles after which IF is forced to win

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
if_req_valid  in  1  IF request present
if_req_ready  out  1  IF request accepted this cycle
if_addr  in  ADDR_W  IF read address
if_rsp_valid  out  1  IF response held
if_rsp_ready  in  1  IF consumes response
if_rsp_data  out  DATA_W  fetched word
ls_req_valid  in  1  LS request present
ls_req_ready  out  1  LS request accepted this cycle
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_W  LS address
ls_wdata  in  DATA_W  LS write data
ls_rsp_valid  out  1  LS response held (read data or write ack)
ls_rsp_ready  in  1  LS consumes response
ls_rsp_data  out  DATA_W  read word; 0 for write ack
mem_wen  out  1  memory write enable
mem_ren  out  1  memory read enable
mem_waddr  out  ADDR_W  memory write address
mem_raddr  out  ADDR_W  memory read address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data (combinational from mem_raddr)

Behaviour:
- Eligibility: a requester is eligible when req_valid=1 and its response slot is free, or is being drained this cycle (rsp_valid & rsp_ready).
- Grant (combinational):
  - LS wins when both are eligible, unless starve_cnt == STARVE_MAX; then IF wins.
  - A single eligible requester always wins.
- req_ready = granted. A handshake occurs on valid & ready. Requesters hold valid and fields stable until ready.
- Memory drive (combinational from grant):
  - IF granted: mem_ren=1, mem_raddr=if_addr.
  - LS read: mem_ren=1, mem_raddr=ls_addr.
  - LS write: mem_wen=1, mem_waddr=ls_addr, mem_wdata=ls_wdata. Memory commits at that clk edge.
  - No grant: mem_wen=mem_ren=0; addresses and data are driven 0.
- Response latency: exactly 1 cycle. At the grant edge, mem_rdata (or 0 for a write) is captured into the granted slot and rsp_valid=1 the next cycle.
- Each slot holds its response until rsp_ready=1, then clears. Simultaneous drain and new grant: slot reloads, rsp_valid stays 1.
- One outstanding response per requester. The other requester is unaffected by a stalled slot.
- starve_cnt (clog2(STARVE_MAX+1) bits):
  - Increments when IF is eligible and not granted.
  - Saturates at STARVE_MAX.
  - Clears on IF grant.
  - Holds when IF is not eligible.
- Per-slot FSM states: EMPTY, FULL.
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on rsp_ready without grant.
  - FULL -> FULL on rsp_ready with grant, or on no rsp_ready.
- Reset (any time, including mid-transfer):
  - Both slots EMPTY; rsp_valid=0 and rsp_data=0.
  - starve_cnt=0.
  - In-flight responses are dropped; no memory write is issued during reset.
- Address wrap is the memory's concern; addresses are passed through unmodified.

Optional Feature:
MEM_PORT_ARBITER_STATS_EN
- Defined: adds 32-bit wrapping counters, reset to 0, on output ports:
  - stat_if_grants: IF handshakes
  - stat_ls_grants: LS handshakes
  - stat_if_stall: cycles with if_req_valid=1 and if_req_ready=0
- Undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package mem_port_arbiter_pkg:
  - ADDR_W and DATA_W defaults.
  - typedef enum grant_e {GNT_NONE, GNT_IF, GNT_LS}.
  - typedef enum slot_state_e {SLOT_EMPTY, SLOT_FULL}.
- Sub-module mem_port_rsp_slot: one-entry response register with load/valid/ready. Instantiated twice (IF, LS).

Test Plan:
- Reset, then IF read of addr 0x0004 holding 0xDEADBEEF with if_rsp_ready=1 -> mem_ren=1 and mem_raddr=0x0004 in the grant cycle; if_rsp_valid=1 and if_rsp_data=0xDEADBEEF the next cycle; one-cycle pulse.
- LS write addr 0x0010 data 0x12345678, then LS read 0x0010 -> write ack with ls_rsp_data=0; read returns 0x12345678.
- Both valid continuously, STARVE_MAX=4 -> four LS grants, then one IF grant, and the pattern repeats; starve_cnt never exceeds 4.
- ls_rsp_ready=0 with LS response held -> ls_req_ready=0 while IF grants continue every cycle. ls_rsp_ready=1 with a new ls_req_valid -> same-cycle drain and reload; ls_rsp_valid stays 1.
- rst_n asserted while both slots are FULL -> all rsp_valid=0 immediately (asynchronous); after release, the first grant behaves as from reset.
- With MEM_PORT_ARBITER_STATS_EN, 10 IF grants and 3 IF stall cycles -> stat_if_grants=10 and stat_if_stall=3.
